// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg
// Shared definitions for the OV7670 capture path:
//   - default frame geometry (640 x 480 active pixels)
//   - capture FSM state encoding
//   - RGB565 field positions and small arithmetic helpers
package cam_capture_pkg;

    localparam int CAM_H_ACTIVE = 640;
    localparam int CAM_V_ACTIVE = 480;

    // RGB565 word layout: R in the top 5 bits, G in the middle 6, B in the low 5.
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    // state     | meaning
    // ----------+-------------------------------------------------------
    // WAIT_VS   | after reset: wait for v_sync high, never join mid-frame
    // WAIT_FS   | in vertical blanking, waiting for the v_sync fall
    // ACTIVE    | capturing lines until the next v_sync rise
    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        WAIT_FS = 2'd1,
        ACTIVE  = 2'd2
    } cam_state_e;

    // Unweighted R5 + G6 + B5; never exceeds 125, so 7 bits suffice.
    function automatic logic [6:0] rgb565_sum(input logic [15:0] w);
        rgb565_sum = {2'b00, w[RGB_R_MSB:RGB_R_LSB]}
                   + {1'b0,  w[RGB_G_MSB:RGB_G_LSB]}
                   + {2'b00, w[RGB_B_MSB:RGB_B_LSB]};
    endfunction

    // Counters that may be pushed past their useful range by oversize
    // lines/frames hold at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cam_rgb_quant.sv
// cam_rgb_quant
// RGB565 -> 2-bit quantiser with a registered output. The quantised value
// is the top two bits of R5+G6+B5. An override input lets the test-pattern
// path reuse the same output register so both sources share identical timing.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   load     in   capture a new value into the output register
//   rgb      in   RGB565 word
//   ovr_en   in   select ovr_val instead of the quantised word
//   ovr_val  in   2-bit override value
//   q        out  registered 2-bit pixel
module cam_rgb_quant (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] rgb,
    input  logic        ovr_en,
    input  logic [1:0]  ovr_val,
    output logic [1:0]  q
);
    import cam_capture_pkg::*;

    logic [6:0] sum;
    logic [1:0] q_d;
    logic [1:0] q_q;

    always_comb begin
        sum = rgb565_sum(rgb);
        q_d = q_q;
        if (load) begin
            q_d = ovr_en ? ovr_val : 2'(sum >> 5);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 2'b00;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cam_capture.sv
// cam_capture
// Camera-side capture stage: pairs RGB565 bytes into pixels, decimates by
// DECIM in both axes, quantises kept pixels to 2 bits and writes them into
// the frame buffer. Reports frame completion and bad line lengths.
// Optional build macro: CAM_CAPTURE_TEST_PATTERN_EN adds input test_mode,
// which replaces camera data with x[5:4]^y[5:4] without changing timing.
// Ports:
//   pclk        in   camera pixel clock (only clock)
//   reset       in   asynchronous active-high reset
//   data_in     in   camera byte bus
//   h_ref       in   line-valid
//   v_sync      in   vertical blanking; falling edge starts a frame
//   test_mode   in   (macro only) select test pattern
//   wr_en       out  one-cycle frame-buffer write strobe
//   wr_addr     out  running write index, saturating
//   wr_data     out  2-bit pixel
//   frame_done  out  one-cycle pulse on end of a captured frame
//   line_err    out  sticky bad-line-length flag
//   frame_cnt   out  completed frame count, wrapping
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int H_ACTIVE = CAM_H_ACTIVE,
    parameter int V_ACTIVE = CAM_V_ACTIVE,
    parameter int DECIM    = 4,
    parameter int ADDR_W   = 15
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [7:0]        data_in,
    input  logic              h_ref,
    input  logic              v_sync,
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_data,
    output logic              frame_done,
    output logic              line_err,
    output logic [7:0]        frame_cnt
);

    localparam logic [15:0] H_LIM      = 16'(H_ACTIVE);
    localparam logic [15:0] V_LIM      = 16'(V_ACTIVE);
    localparam logic [15:0] BYTES_LINE = 16'(2 * H_ACTIVE);
    localparam logic [15:0] D_MASK     = 16'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX =
        ADDR_W'((H_ACTIVE / DECIM) * (V_ACTIVE / DECIM) - 1);

    logic tm_sel;
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    assign tm_sel = test_mode;
`else
    assign tm_sel = 1'b0;
`endif

    // Input registers plus one extra stage on the sync lines for edge detect.
    logic [7:0] data_q;
    logic       h_ref_q, h_ref_p;
    logic       v_sync_q, v_sync_p;

    cam_state_e        state_q, state_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic [15:0]       x_q, x_d;
    logic [15:0]       y_q, y_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    // Pixel stage: a completed, kept pixel waiting for quantisation.
    logic              pix_vld_q, pix_vld_d;
    logic [15:0]       pix_word_q, pix_word_d;
    logic [1:0]        pix_tp_q, pix_tp_d;
    logic              pix_tm_q, pix_tm_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic vs_rise, vs_fall, hr_fall, keep;

    always_comb begin
        vs_rise = v_sync_q & ~v_sync_p;
        vs_fall = ~v_sync_q & v_sync_p;
        hr_fall = ~h_ref_q & h_ref_p;
        keep    = ((x_q & D_MASK) == 16'd0) && ((y_q & D_MASK) == 16'd0)
                  && (x_q < H_LIM) && (y_q < V_LIM);

        state_d      = state_q;
        phase_d      = 1'b0;
        hi_byte_d    = hi_byte_q;
        x_d          = x_q;
        y_d          = y_q;
        byte_cnt_d   = byte_cnt_q;
        pix_vld_d    = 1'b0;
        pix_word_d   = pix_word_q;
        pix_tp_d     = pix_tp_q;
        pix_tm_d     = pix_tm_q;
        wr_en_d      = pix_vld_q;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;
        frame_cnt_d  = frame_cnt_q;

        // Advance after each write; a write that drains after the frame has
        // ended still advances, and the next frame start clears it anyway.
        if (wr_en_q && (wr_addr_q != ADDR_MAX)) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end

        case (state_q)
            WAIT_VS: begin
                if (v_sync_q) begin
                    state_d = WAIT_FS;
                end
            end
            WAIT_FS: begin
                if (vs_fall) begin
                    state_d    = ACTIVE;
                    x_d        = 16'd0;
                    y_d        = 16'd0;
                    byte_cnt_d = 16'd0;
                    wr_addr_d  = '0;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // Any half-assembled pixel is abandoned; phase already
                    // defaults back to 0.
                    state_d      = WAIT_FS;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                end else if (h_ref_q) begin
                    phase_d    = ~phase_q;
                    byte_cnt_d = sat_inc16(byte_cnt_q);
                    if (!phase_q) begin
                        hi_byte_d = data_q;
                    end else begin
                        x_d        = sat_inc16(x_q);
                        pix_vld_d  = keep;
                        pix_word_d = {hi_byte_q, data_q};
                        pix_tp_d   = x_q[5:4] ^ y_q[5:4];
                        pix_tm_d   = tm_sel;
                    end
                end else if (hr_fall) begin
                    x_d        = 16'd0;
                    y_d        = sat_inc16(y_q);
                    byte_cnt_d = 16'd0;
                    if (byte_cnt_q != BYTES_LINE) begin
                        line_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = WAIT_VS;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            data_q       <= 8'd0;
            h_ref_q      <= 1'b0;
            h_ref_p      <= 1'b0;
            v_sync_q     <= 1'b0;
            v_sync_p     <= 1'b0;
            state_q      <= WAIT_VS;
            phase_q      <= 1'b0;
            hi_byte_q    <= 8'd0;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            byte_cnt_q   <= 16'd0;
            pix_vld_q    <= 1'b0;
            pix_word_q   <= 16'd0;
            pix_tp_q     <= 2'b00;
            pix_tm_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            data_q       <= data_in;
            h_ref_q      <= h_ref;
            h_ref_p      <= h_ref_q;
            v_sync_q     <= v_sync;
            v_sync_p     <= v_sync_q;
            state_q      <= state_d;
            phase_q      <= phase_d;
            hi_byte_q    <= hi_byte_d;
            x_q          <= x_d;
            y_q          <= y_d;
            byte_cnt_q   <= byte_cnt_d;
            pix_vld_q    <= pix_vld_d;
            pix_word_q   <= pix_word_d;
            pix_tp_q     <= pix_tp_d;
            pix_tm_q     <= pix_tm_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // The quantiser register loads alongside wr_en_q so data and strobe align.
    cam_rgb_quant u_quant (
        .clk     (pclk),
        .rst     (reset),
        .load    (pix_vld_q),
        .rgb     (pix_word_q),
        .ovr_en  (pix_tm_q),
        .ovr_val (pix_tp_q),
        .q       (wr_data)
    );

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_capture.sv
module tb_cam_capture;

    localparam int H     = 32;
    localparam int V     = 16;
    localparam int D     = 4;
    localparam int AW    = 5;
    localparam int NKEEP = (H / D) * (V / D);

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    data_in = 8'd0;
    logic          h_ref = 1'b0;
    logic          v_sync = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_data;
    logic          frame_done;
    logic          line_err;
    logic [7:0]    frame_cnt;

    cam_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .DECIM    (D),
        .ADDR_W   (AW)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .data_in    (data_in),
        .h_ref      (h_ref),
        .v_sync     (v_sync),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  failures = 0;
    int  wr_idx = 0;
    bit  model_active = 1'b0;
    int  exp_frames = 0;
    int  got_frames = 0;
    bit  exp_line_err = 1'b0;

    // Reference quantiser: sum of the three colour fields, top two of 7 bits.
    function automatic int quant(input int w);
        return (((w >> 11) & 31) + ((w >> 5) & 63) + (w & 31)) / 32;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (frame_done === 1'b1) got_frames++;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr=%0d data=%0d, no write expected",
                         wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), mon_e.addr);
                check("wr_data", int'(wr_data), mon_e.data);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic vs_pulse();
        if (model_active) exp_frames++;
        v_sync = 1'b1;
        repeat (4) tick();
        v_sync = 1'b0;
        repeat (3) tick();
        model_active = 1'b1;
        wr_idx = 0;
    endtask

    // rst_x >= 0: assert reset shortly after that pixel completes, while
    // its write is still in flight.
    task automatic drive_line(input int npix, input int mode, input int y, input int rst_x);
        for (int x = 0; x < npix; x++) begin
            int  w;
            wr_t e;
            case (mode)
                0:       w = 'hFFFF;
                1:       w = 0;
                2:       w = 'h8410;
                default: w = int'($urandom_range(0, 65535));
            endcase
            h_ref   = 1'b1;
            data_in = w[15:8];
            tick();
            data_in = w[7:0];
            if (x == rst_x) begin
                tick();
                tick();
                reset = 1'b1;
                #1;
                check("rst_wr_en_async", int'(wr_en), 0);
                exp_q.delete();
                model_active = 1'b0;
                exp_frames   = 0;
                got_frames   = 0;
                exp_line_err = 1'b0;
                wr_idx       = 0;
                h_ref        = 1'b0;
                tick();
                check("rst_wr_en_next", int'(wr_en), 0);
                check("rst_frame_cnt", int'(frame_cnt), 0);
                check("rst_line_err", int'(line_err), 0);
                check("rst_wr_addr", int'(wr_addr), 0);
                repeat (3) tick();
                reset = 1'b0;
                repeat (2) tick();
                return;
            end
            if (model_active && (x % D == 0) && (y % D == 0) && (x < H) && (y < V)) begin
                e.addr = (wr_idx < NKEEP - 1) ? wr_idx : NKEEP - 1;
                e.data = quant(w);
                exp_q.push_back(e);
                wr_idx++;
            end
            tick();
        end
        h_ref   = 1'b0;
        data_in = 8'd0;
        if (model_active && (npix != H)) exp_line_err = 1'b1;
        repeat (4) tick();
    endtask

    task automatic run_frame(input int nlines, input int npix, input int mode,
                             input int short_y, input int rst_y, input int rst_x);
        for (int y = 0; y < nlines; y++) begin
            drive_line((y == short_y) ? H - 2 : npix, mode, y,
                       (y == rst_y) ? rst_x : -1);
        end
    endtask

    task automatic end_frame(input string name);
        repeat (2) tick();
        check({name, "_last_addr"}, int'(wr_addr), (wr_idx < NKEEP - 1) ? wr_idx : NKEEP - 1);
        vs_pulse();
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_frame_done"}, got_frames, exp_frames);
        check({name, "_frame_cnt"}, int'(frame_cnt), exp_frames % 256);
        check({name, "_line_err"}, int'(line_err), int'(exp_line_err));
    endtask

    initial begin
        reset  = 1'b1;
        v_sync = 1'b0;
        repeat (5) tick();
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_wr_addr", int'(wr_addr), 0);
        check("reset_wr_data", int'(wr_data), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_line_err", int'(line_err), 0);
        check("reset_frame_cnt", int'(frame_cnt), 0);
        reset = 1'b0;
        repeat (2) tick();

        // v_sync already low after reset: lines must be ignored.
        run_frame(4, H, 3, -1, -1, -1);
        end_frame("midstart");

        run_frame(V, H, 0, -1, -1, -1);
        end_frame("all_ff");
        run_frame(V, H, 1, -1, -1, -1);
        end_frame("all_00");
        run_frame(V, H, 2, -1, -1, -1);
        end_frame("w8410");
        run_frame(V, H, 3, 2, -1, -1);
        end_frame("short_line");
        run_frame(V + 4, H + 8, 3, -1, -1, -1);
        end_frame("oversize");
        run_frame(V, H, 3, -1, -1, -1);
        end_frame("sticky");

        run_frame(V, H, 3, -1, 4, 4);
        end_frame("after_reset");
        run_frame(V, H, 3, -1, -1, -1);
        end_frame("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
